// File: rtl/paddle_motion.sv
// Multi-channel paddle position controller.
// Each channel accelerates while a direction is held and saturates at the bounds.
module paddle_motion #(
  parameter int N_PADDLES  = 2,
  parameter int POS_W      = 10,
  parameter int Y_MIN      = 0,
  parameter int Y_MAX      = 440,
  parameter int RESET_POS  = 240,
  parameter int STEP_MIN   = 1,
  parameter int STEP_MAX   = 4,
  parameter int ACCEL_HOLD = 8
) (
  input  logic                         slow_clk,
  input  logic                         i_reset,
  input  logic                         i_freeze,
  input  logic [N_PADDLES-1:0]         i_inc,
  input  logic [N_PADDLES-1:0]         i_dec,
  output logic [N_PADDLES*POS_W-1:0]   o_pos,
  output logic [N_PADDLES-1:0]         o_at_min,
  output logic [N_PADDLES-1:0]         o_at_max,
  output logic [N_PADDLES-1:0]         o_moving
);

  localparam int CW = $clog2(ACCEL_HOLD);

  localparam logic [POS_W-1:0] YMIN  = POS_W'(Y_MIN);
  localparam logic [POS_W-1:0] YMAX  = POS_W'(Y_MAX);
  localparam logic [POS_W-1:0] RPOS  = POS_W'(RESET_POS);
  localparam logic [POS_W-1:0] SMIN  = POS_W'(STEP_MIN);
  localparam logic [POS_W-1:0] SMAX  = POS_W'(STEP_MAX);
  localparam logic [POS_W:0]   YMINX = (POS_W+1)'(Y_MIN);
  localparam logic [POS_W:0]   YMAXX = (POS_W+1)'(Y_MAX);
  localparam logic [CW-1:0]    CLAST = CW'(ACCEL_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  genvar k;
  generate
    for (k = 0; k < N_PADDLES; k++) begin : g_ch
      state_t           state_q, state_d;
      logic [POS_W-1:0] pos_q, pos_d;
      logic [POS_W-1:0] spd_q, spd_d;
      logic [POS_W-1:0] step;
      logic [CW-1:0]    cnt_q, cnt_d;
      logic [POS_W:0]   sum;
      logic [POS_W:0]   floor_x;
      logic             up_req;
      logic             dn_req;
      logic             same_dir;

      assign up_req   = i_inc[k] & ~i_dec[k];
      assign dn_req   = i_dec[k] & ~i_inc[k];
      assign same_dir = (up_req && state_q == UP) ||
                        (dn_req && state_q == DOWN);

      always_ff @(posedge slow_clk) begin
        if (i_reset) begin
          state_q <= IDLE;
          pos_q   <= RPOS;
          spd_q   <= SMIN;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          pos_q   <= pos_d;
          spd_q   <= spd_d;
          cnt_q   <= cnt_d;
        end
      end

      always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        spd_d   = spd_q;
        cnt_d   = cnt_q;
        step    = SMIN;
        sum     = '0;
        floor_x = '0;
        if (!i_freeze) begin
          if (!up_req && !dn_req) begin
            state_d = IDLE;
            spd_d   = SMIN;
            cnt_d   = '0;
          end else begin
            if (same_dir) begin
              step = spd_q;
              if (cnt_q == CLAST) begin
                cnt_d = '0;
                spd_d = (spd_q >= SMAX) ? SMAX
                                        : spd_q + POS_W'(1);
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end else begin
              step    = SMIN;
              spd_d   = SMIN;
              cnt_d   = CW'(1);
              state_d = up_req ? UP : DOWN;
            end
            // Bounds are checked one bit wider so no wrap can slip past.
            sum     = {1'b0, pos_q} + {1'b0, step};
            floor_x = YMINX + {1'b0, step};
            if (up_req)
              pos_d = (sum > YMAXX) ? YMAX : sum[POS_W-1:0];
            else
              pos_d = ({1'b0, pos_q} < floor_x) ? YMIN
                                                : pos_q - step;
          end
        end
      end

      assign o_pos[k*POS_W +: POS_W] = pos_q;
      assign o_at_min[k] = (pos_q == YMIN);
      assign o_at_max[k] = (pos_q == YMAX);
      assign o_moving[k] = (state_q != IDLE);
    end
  endgenerate

endmodule

// File: tb/tb_paddle_motion.sv
// Self-checking bench for paddle_motion.
// Randomized and directed stimulus against a behavioural paddle model.
module tb_paddle_motion;

  localparam int NP   = 2;
  localparam int W    = 10;
  localparam int YMIN = 0;
  localparam int YMAX = 440;
  localparam int RP   = 240;
  localparam int SMIN = 1;
  localparam int SMAX = 4;
  localparam int AH   = 8;

  logic            slow_clk;
  logic            i_reset;
  logic            i_freeze;
  logic [NP-1:0]   i_inc;
  logic [NP-1:0]   i_dec;
  logic [NP*W-1:0] o_pos;
  logic [NP-1:0]   o_at_min;
  logic [NP-1:0]   o_at_max;
  logic [NP-1:0]   o_moving;

  int checks;
  int failures;

  // Model: direction 0 = resting, +1 = rising, -1 = falling.
  int m_pos [NP];
  int m_spd [NP];
  int m_cnt [NP];
  int m_dir [NP];

  paddle_motion #(
    .N_PADDLES (NP),
    .POS_W     (W),
    .Y_MIN     (YMIN),
    .Y_MAX     (YMAX),
    .RESET_POS (RP),
    .STEP_MIN  (SMIN),
    .STEP_MAX  (SMAX),
    .ACCEL_HOLD(AH)
  ) dut (
    .slow_clk(slow_clk),
    .i_reset (i_reset),
    .i_freeze(i_freeze),
    .i_inc   (i_inc),
    .i_dec   (i_dec),
    .o_pos   (o_pos),
    .o_at_min(o_at_min),
    .o_at_max(o_at_max),
    .o_moving(o_moving)
  );

  initial slow_clk = 1'b0;
  always #5 slow_clk = ~slow_clk;

  function automatic int pos_of(int k);
    return int'(o_pos[k*W +: W]);
  endfunction

  function automatic logic [2:0] exp_flags(int k);
    return {m_pos[k] == YMIN, m_pos[k] == YMAX, m_dir[k] != 0};
  endfunction

  function automatic logic [2:0] act_flags(int k);
    return {o_at_min[k], o_at_max[k], o_moving[k]};
  endfunction

  // Advance the model with the inputs about to be sampled, then clock.
  task automatic tick();
    for (int k = 0; k < NP; k++) begin
      int req;
      int stp;
      req = (i_inc[k] && !i_dec[k]) ? 1 :
            (i_dec[k] && !i_inc[k]) ? -1 : 0;
      if (i_reset) begin
        m_pos[k] = RP; m_spd[k] = SMIN;
        m_cnt[k] = 0;  m_dir[k] = 0;
      end else if (!i_freeze) begin
        if (req == 0) begin
          m_dir[k] = 0; m_spd[k] = SMIN; m_cnt[k] = 0;
        end else begin
          if (req == m_dir[k]) begin
            stp = m_spd[k];
            m_cnt[k]++;
            if (m_cnt[k] == AH) begin
              m_cnt[k] = 0;
              m_spd[k] = (m_spd[k] + 1 > SMAX) ? SMAX : m_spd[k] + 1;
            end
          end else begin
            stp = SMIN;
            m_spd[k] = SMIN; m_cnt[k] = 1; m_dir[k] = req;
          end
          m_pos[k] = m_pos[k] + req * stp;
          if (m_pos[k] > YMAX) m_pos[k] = YMAX;
          if (m_pos[k] < YMIN) m_pos[k] = YMIN;
        end
      end
    end
    @(posedge slow_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_freeze = 1'b0; i_inc = '0; i_dec = '0;
    tick();
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      i_freeze = 1'($urandom);
      i_inc = NP'($urandom);
      i_dec = NP'($urandom);
      tick();
    end
    i_reset = 1'b0; i_freeze = 1'b0; i_inc = '0; i_dec = '0;
    tick();
    for (int k = 0; k < NP; k++) begin
      checks++;
      if (pos_of(k) !== 240)
        $display("FAIL reset_pos ch%0d got=%0d exp=240", k, pos_of(k));
      else continue;
      failures++;
    end
    for (int k = 0; k < NP; k++) begin
      checks++;
      if (act_flags(k) !== 3'b000) begin
        failures++;
        $display("FAIL reset_flags ch%0d got=%b exp=000", k, act_flags(k));
      end
    end
  endtask

  task automatic test_accel();
    int tbl [20] = '{241, 242, 243, 244, 245, 246, 247, 248,
                     250, 252, 254, 256, 258, 260, 262, 264,
                     267, 270, 273, 276};
    do_reset();
    i_inc = 2'b01;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (pos_of(0) !== tbl[c] || pos_of(0) !== m_pos[0]) begin
        failures++;
        $display("FAIL accel ch0 move%0d got=%0d exp=%0d",
                 c + 1, pos_of(0), tbl[c]);
      end
      checks++;
      if (pos_of(1) !== 240) begin
        failures++;
        $display("FAIL accel ch1 move%0d got=%0d exp=240", c + 1, pos_of(1));
      end
    end
    i_inc = '0;
  endtask

  task automatic test_sat_min();
    int  budget;
    bit  hit;
    do_reset();
    i_dec = 2'b10;
    budget = 0;
    hit = 0;
    while (!hit && budget < 400) begin
      tick();
      budget++;
      checks++;
      if (pos_of(1) !== m_pos[1] || pos_of(1) > 240) begin
        failures++;
        $display("FAIL sat_min_track got=%0d exp=%0d", pos_of(1), m_pos[1]);
      end
      if (pos_of(1) == 0) hit = 1;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL sat_min_timeout got=%0d exp=0", pos_of(1));
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (pos_of(1) !== 0 || act_flags(1) !== 3'b101) begin
        failures++;
        $display("FAIL sat_min_hold got=%0d/%b exp=0/101",
                 pos_of(1), act_flags(1));
      end
    end
    i_dec = '0;
  endtask

  task automatic test_sat_max();
    int budget;
    do_reset();
    i_inc = 2'b11;
    budget = 0;
    while (o_at_max !== 2'b11 && budget < 400) begin
      tick();
      budget++;
      for (int k = 0; k < NP; k++) begin
        checks++;
        if (pos_of(k) !== m_pos[k] || act_flags(k) !== exp_flags(k)) begin
          failures++;
          $display("FAIL sat_max_track ch%0d got=%0d/%b exp=%0d/%b",
                   k, pos_of(k), act_flags(k), m_pos[k], exp_flags(k));
        end
      end
    end
    tick();
    checks++;
    if (pos_of(0) !== 440 || pos_of(1) !== 440 || o_at_max !== 2'b11) begin
      failures++;
      $display("FAIL sat_max_hold got=%0d,%0d exp=440,440",
               pos_of(0), pos_of(1));
    end
    i_inc = '0;
  endtask

  task automatic test_both();
    do_reset();
    i_inc = 2'b01;
    repeat (10) tick();
    checks++;
    if (pos_of(0) !== 252) begin
      failures++;
      $display("FAIL both_pre got=%0d exp=252", pos_of(0));
    end
    i_dec = 2'b01;
    tick();
    checks++;
    if (pos_of(0) !== 252 || o_moving[0] !== 1'b0) begin
      failures++;
      $display("FAIL both_hold got=%0d/%b exp=252/0", pos_of(0), o_moving[0]);
    end
    i_dec = '0;
    tick();
    checks++;
    if (pos_of(0) !== 253 || pos_of(0) !== m_pos[0]) begin
      failures++;
      $display("FAIL both_restart got=%0d exp=253", pos_of(0));
    end
    i_inc = '0;
  endtask

  task automatic test_freeze();
    do_reset();
    i_inc = 2'b01;
    repeat (18) tick();
    i_freeze = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (pos_of(0) !== 270 || o_moving[0] !== 1'b1) begin
        failures++;
        $display("FAIL freeze_hold c%0d got=%0d exp=270", c, pos_of(0));
      end
    end
    i_freeze = 1'b0;
    tick();
    checks++;
    if (pos_of(0) !== 273) begin
      failures++;
      $display("FAIL freeze_resume got=%0d exp=273", pos_of(0));
    end
    repeat (6) tick();
    checks++;
    if (pos_of(0) !== 292 || pos_of(0) !== m_pos[0]) begin
      failures++;
      $display("FAIL freeze_accel got=%0d exp=292", pos_of(0));
    end
    i_inc = '0;
  endtask

  task automatic test_reset_override();
    do_reset();
    i_inc = 2'b01;
    repeat (18) tick();
    i_reset = 1'b1;
    i_freeze = 1'b1;
    tick();
    i_reset = 1'b0;
    i_freeze = 1'b0;
    checks++;
    if (pos_of(0) !== 240 || o_moving[0] !== 1'b0) begin
      failures++;
      $display("FAIL rst_override got=%0d/%b exp=240/0",
               pos_of(0), o_moving[0]);
    end
    tick();
    checks++;
    if (pos_of(0) !== 241) begin
      failures++;
      $display("FAIL rst_override_step got=%0d exp=241", pos_of(0));
    end
    i_inc = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      i_reset  = ($urandom_range(0, 79) == 0);
      i_freeze = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < NP; k++) begin
        int r;
        r = $urandom_range(0, 9);
        i_inc[k] = (r < 5) || (r == 9);
        i_dec[k] = (r >= 5);
      end
      tick();
      for (int k = 0; k < NP; k++) begin
        checks++;
        if (pos_of(k) !== m_pos[k] || act_flags(k) !== exp_flags(k)) begin
          failures++;
          $display("FAIL random c%0d ch%0d got=%0d/%b exp=%0d/%b",
                   c, k, pos_of(k), act_flags(k), m_pos[k], exp_flags(k));
        end
      end
    end
    i_reset = 1'b0; i_freeze = 1'b0; i_inc = '0; i_dec = '0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    i_reset = 1'b1;
    i_freeze = 1'b0;
    i_inc = '0;
    i_dec = '0;
    for (int k = 0; k < NP; k++) begin
      m_pos[k] = RP; m_spd[k] = SMIN; m_cnt[k] = 0; m_dir[k] = 0;
    end
    #2;
    test_reset();
    test_accel();
    test_sat_min();
    test_sat_max();
    test_both();
    test_freeze();
    test_reset_override();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/paddle_motion.md
PADDLE_MOTION -- requirements
Module: paddle_motion

Interface
REQ-001 Parameter N_PADDLES, default 2: number of independent paddle channels (1..8).
REQ-002 Parameter POS_W, default 10: position width in bits.
REQ-003 Parameter Y_MIN, default 0: lowest legal position.
REQ-004 Parameter Y_MAX, default 440: highest legal position (Y_MIN < Y_MAX < 2^POS_W).
REQ-005 Parameter RESET_POS, default 240: position loaded on reset (Y_MIN <= RESET_POS <= Y_MAX).
REQ-006 Parameter STEP_MIN, default 1: initial step per move (>= 1).
REQ-007 Parameter STEP_MAX, default 4: maximum step per move (STEP_MIN <= STEP_MAX <= Y_MAX-Y_MIN).
REQ-008 Parameter ACCEL_HOLD, default 8: moves per speed level before acceleration (>= 2).
REQ-009 slow_clk  in  1  clock; all state updates on rising edge.
REQ-010 i_reset  in  1  reset i_reset, synchronous, active-high; clock slow_clk.
REQ-011 i_freeze  in  1  pause; when high, all channel state is held.
REQ-012 i_inc  in  N_PADDLES  per-channel request to increase position.
REQ-013 i_dec  in  N_PADDLES  per-channel request to decrease position.
REQ-014 o_pos  out  N_PADDLES*POS_W  packed positions; channel k at bits [k*POS_W +: POS_W].
REQ-015 o_at_min  out  N_PADDLES  channel position equals Y_MIN.
REQ-016 o_at_max  out  N_PADDLES  channel position equals Y_MAX.
REQ-017 o_moving  out  N_PADDLES  channel state is UP or DOWN.

Function
REQ-018 Each channel SHALL hold registers pos (POS_W), speed, cnt (ACCEL_HOLD counter), and a 3-state FSM {IDLE, UP, DOWN}; channels are fully independent.
REQ-019 o_pos, o_at_min, o_at_max, o_moving SHALL be derived only from registered state (no combinational input-to-output path).
REQ-020 Per-cycle request decode: inc-only = UP request, dec-only = DOWN request, neither or both = no request.
REQ-021 No request: state->IDLE, speed<=STEP_MIN, cnt<=0, pos unchanged.
REQ-022 Request matching current state (UP in UP, DOWN in DOWN): pos moves by current speed; cnt<=cnt+1; if cnt==ACCEL_HOLD-1 then cnt<=0 and speed<=min(speed+1, STEP_MAX).
REQ-023 Request from IDLE or reversal (UP in DOWN, DOWN in UP): pos moves by STEP_MIN; speed<=STEP_MIN; cnt<=1; state->requested direction.
REQ-024 UP move: pos <= min(pos+step, Y_MAX), computed in POS_W+1 bits; no wrap-around.
REQ-025 DOWN move: pos <= Y_MIN if pos < Y_MIN+step, else pos-step; no underflow.
REQ-026 At a clamp, state, speed and cnt SHALL update per REQ-022/023 as if unclamped; only pos saturates.
REQ-027 i_freeze high SHALL hold pos, speed, cnt and state in every channel, regardless of requests; i_reset overrides i_freeze.
REQ-028 Latency: a request sampled at edge n is reflected on o_pos after edge n (one cycle).

Reset
REQ-029 While i_reset is high at a slow_clk edge, every channel SHALL load pos=RESET_POS, speed=STEP_MIN, cnt=0, state=IDLE, irrespective of i_freeze, i_inc, i_dec.
REQ-030 Post-reset outputs: o_pos all RESET_POS, o_moving=0, o_at_min/o_at_max = (RESET_POS==Y_MIN)/(RESET_POS==Y_MAX), i.e. 0 for defaults.

Verification (defaults)
REQ-031 Reset, then idle inputs -> o_pos ch0=ch1=240, all flags 0.
REQ-032 Hold i_inc[0] 20 cycles -> ch0 positions 241..248 (step 1), 250..264 (step 2), 267..276 (step 3); ch1 stays 240.
REQ-033 Hold i_dec[1] until saturation -> pos never below 0, final 0, o_at_min[1]=1, o_moving[1]=1, holds 0 on further cycles.
REQ-034 After 10 inc moves (speed 2), drive inc+dec 1 cycle then inc -> pos unchanged on the both-pressed cycle, next move +1.
REQ-035 Mid-acceleration at speed 3, raise i_freeze 5 cycles with inc held -> pos frozen; after release, acceleration sequence resumes exactly where paused.
REQ-036 At speed 3 moving UP, assert i_reset 1 cycle with i_freeze=1 -> pos=240, o_moving=0; next inc move is +1.
